// File: rtl/tick_scheduler_if.sv
// Configuration port of the tick scheduler: one valid/ready request per
// channel update (period, enable, phase-sync).
interface tick_scheduler_if #(
  parameter int CHW = 2,
  parameter int W   = 16
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_period;
  logic           cfg_en;
  logic           cfg_sync;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_en,
    output cfg_sync,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_en,
    input  cfg_sync,
    output cfg_ready
  );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: per-channel down-counters reload from
// a programmable period and emit a one-cycle tick plus a divided square wave.
//
// state  | meaning
// IDLE   | cfg_ready high, waiting for a configuration request
// LOAD   | request latched, applied to the channels at the next edge
module tick_scheduler #(
  parameter int CH  = 4,
  parameter int CHW = 2,
  parameter int W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  tick_scheduler_if.slave     cfg,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       div_clk,
  output logic [CH-1:0]       active
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_ready;
  logic           w_accept;
  logic           w_load;

  logic [CHW-1:0] r_ch;
  logic [W-1:0]   r_period;
  logic           r_en;
  logic           r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cfg.cfg_valid) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cfg.cfg_ready = w_ready;
  assign w_accept      = w_ready && cfg.cfg_valid;
  assign w_load        = (r_state == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch     <= '0;
      r_period <= '0;
      r_en     <= 1'b0;
      r_sync   <= 1'b0;
    end else if (w_accept) begin
      r_ch     <= cfg.cfg_ch;
      r_period <= cfg.cfg_period;
      r_en     <= cfg.cfg_en;
      r_sync   <= cfg.cfg_sync;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : gen_ch
    logic [W-1:0] r_per;
    logic [W-1:0] r_cnt;
    logic         r_tick;
    logic         r_div;
    logic         r_act;
    logic         w_tgt;
    logic         w_act_nxt;
    logic         w_restart;
    logic [W-1:0] w_per_nxt;

    // An out-of-range r_ch never matches, so such requests only act via sync.
    assign w_tgt     = w_load && (r_ch == CHW'(g));
    assign w_per_nxt = w_tgt ? r_period : r_per;
    assign w_act_nxt = w_tgt ? r_en : r_act;
    assign w_restart = w_act_nxt && ((w_tgt && !r_act) || (w_load && r_sync));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_per  <= '0;
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_div  <= 1'b0;
        r_act  <= 1'b0;
      end else begin
        r_per <= w_per_nxt;
        r_act <= w_act_nxt;
        if (!w_act_nxt) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_div  <= 1'b0;
        end else if (w_restart) begin
          r_cnt  <= w_per_nxt;
          r_tick <= 1'b0;
          r_div  <= 1'b0;
        end else if (r_cnt == '0) begin
          // A retune landing on the reload edge already takes the new period.
          r_cnt  <= w_per_nxt;
          r_tick <= 1'b1;
          r_div  <= ~r_div;
        end else begin
          r_cnt  <= r_cnt - W'(1);
          r_tick <= 1'b0;
        end
      end
    end

    assign tick[g]    = r_tick;
    assign div_clk[g] = r_div;
    assign active[g]  = r_act;
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (3 channels, 2-bit index): expectations are
// queued per edge number and checked by an independent negedge monitor.
module tb_tick_scheduler;
  localparam int CH  = 3;
  localparam int CHW = 2;
  localparam int W   = 16;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] tick;
  logic [CH-1:0] div_clk;
  logic [CH-1:0] active;

  tick_scheduler_if #(.CHW(CHW), .W(W)) u_if ();

  tick_scheduler #(.CH(CH), .CHW(CHW), .W(W)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg    (u_if),
    .tick   (tick),
    .div_clk(div_clk),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [2:0] m;
    logic [2:0] tk;
    logic [2:0] dv;
    logic [2:0] ac;
    bit         crdy;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void expect_at(input int cyc, input string nm, input logic [2:0] m,
                                    input logic [2:0] tk, input logic [2:0] dv,
                                    input logic [2:0] ac, input bit crdy, input logic rdy);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.m = m; e.tk = tk; e.dv = dv; e.ac = ac;
    e.crdy = crdy; e.rdy = rdy;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= ecount) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != ecount ||
          (tick & e.m) !== (e.tk & e.m) ||
          (div_clk & e.m) !== (e.dv & e.m) ||
          (active & e.m) !== (e.ac & e.m) ||
          (e.crdy && u_if.cfg_ready !== e.rdy)) begin
        n_fail++;
        $display("FAIL %s @edge %0d (due %0d): got tick=%b div=%b active=%b ready=%b, want tick=%b div=%b active=%b ready=%b mask=%b",
                 e.nm, ecount, e.cyc, tick, div_clk, active, u_if.cfg_ready,
                 e.tk, e.dv, e.ac, e.crdy ? e.rdy : 1'bx, e.m);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  task automatic do_cfg(input logic [CHW-1:0] ch, input logic [W-1:0] p,
                        input logic en, input logic sy, output int a);
    int k;
    k = 0;
    @(negedge clk);
    while (u_if.cfg_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k == 8) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cfg_ready_timeout: ready=%b, required 1", u_if.cfg_ready);
    end
    a = ecount + 1;
    u_if.cfg_valid  = 1'b1;
    u_if.cfg_ch     = ch;
    u_if.cfg_period = p;
    u_if.cfg_en     = en;
    u_if.cfg_sync   = sy;
    @(posedge clk);
    #1;
    u_if.cfg_valid  = 1'b0;
    u_if.cfg_sync   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int a, t, e, l;
    rst_n           = 1'b0;
    u_if.cfg_valid  = 1'b0;
    u_if.cfg_ch     = '0;
    u_if.cfg_period = '0;
    u_if.cfg_en     = 1'b0;
    u_if.cfg_sync   = 1'b0;
    wait_edge(2);
    rst_n = 1'b1;

    // Start: ch0, P=3
    do_cfg(2'd0, 16'd3, 1'b1, 1'b0, a);
    expect_at(a,      "A_accept", 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(a + 1,  "A_load",   3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 1'b1);
    expect_at(a + 4,  "A_pre",    3'b001, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    expect_at(a + 5,  "A_tick1",  3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0);
    expect_at(a + 6,  "A_gap",    3'b001, 3'b000, 3'b001, 3'b001, 1'b0, 1'b0);
    expect_at(a + 9,  "A_tick2",  3'b001, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0);
    expect_at(a + 13, "A_tick3",  3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0);
    wait_edge(a + 13);

    // Async reset while tick[0] is high, checked before the next clk edge
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tick !== '0 || div_clk !== '0 || active !== '0 || u_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got tick=%b div=%b active=%b ready=%b, want 000 000 000 1",
               tick, div_clk, active, u_if.cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fastest rate: ch1, P=0
    do_cfg(2'd1, 16'd0, 1'b1, 1'b0, a);
    e = a + 1;
    expect_at(a,     "B_accept", 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(e,     "B_load",   3'b010, 3'b000, 3'b000, 3'b010, 1'b1, 1'b1);
    expect_at(e + 1, "B_t1",     3'b010, 3'b010, 3'b010, 3'b010, 1'b0, 1'b0);
    expect_at(e + 2, "B_t2",     3'b010, 3'b010, 3'b000, 3'b010, 1'b0, 1'b0);
    expect_at(e + 3, "B_t3",     3'b010, 3'b010, 3'b010, 3'b010, 1'b0, 1'b0);
    wait_edge(e + 4);
    do_reset();

    // Retune: ch0 P=3 ticks at t, P=1 loaded at t+2
    do_cfg(2'd0, 16'd3, 1'b1, 1'b0, a);
    t = a + 5;
    expect_at(t, "C_tick_t", 3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0);
    wait_edge(t - 1);
    do_cfg(2'd0, 16'd1, 1'b1, 1'b0, a);
    expect_at(t + 3, "C_t3", 3'b001, 3'b000, 3'b001, 3'b001, 1'b0, 1'b0);
    expect_at(t + 4, "C_t4", 3'b001, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0);
    expect_at(t + 5, "C_t5", 3'b001, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
    expect_at(t + 6, "C_t6", 3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0);
    expect_at(t + 8, "C_t8", 3'b001, 3'b001, 3'b000, 3'b001, 1'b0, 1'b0);
    wait_edge(t + 9);
    do_reset();

    // Sync: ch0 P=3, ch1 P=5 running; ch2 P=2 with sync
    do_cfg(2'd0, 16'd3, 1'b1, 1'b0, a);
    do_cfg(2'd1, 16'd5, 1'b1, 1'b0, a);
    wait_edge(a + 5);
    do_cfg(2'd2, 16'd2, 1'b1, 1'b1, a);
    e = a + 1;
    expect_at(e,     "D_load", 3'b111, 3'b000, 3'b000, 3'b111, 1'b1, 1'b1);
    expect_at(e + 3, "D_e3",   3'b111, 3'b100, 3'b100, 3'b111, 1'b0, 1'b0);
    expect_at(e + 4, "D_e4",   3'b111, 3'b001, 3'b101, 3'b111, 1'b0, 1'b0);
    expect_at(e + 5, "D_e5",   3'b111, 3'b000, 3'b101, 3'b111, 1'b0, 1'b0);
    expect_at(e + 6, "D_e6",   3'b111, 3'b110, 3'b011, 3'b111, 1'b0, 1'b0);

    // Disable ch0 on the edge where it would have ticked
    wait_edge(e + 5);
    do_cfg(2'd0, 16'd3, 1'b0, 1'b0, a);
    expect_at(e + 8,  "E_load", 3'b111, 3'b000, 3'b010, 3'b110, 1'b1, 1'b1);
    expect_at(e + 9,  "E_e9",   3'b111, 3'b100, 3'b110, 3'b110, 1'b0, 1'b0);
    expect_at(e + 12, "E_e12",  3'b111, 3'b110, 3'b000, 3'b110, 1'b0, 1'b0);

    // Out-of-range channel: handshake only
    wait_edge(e + 11);
    do_cfg(2'd3, 16'd7, 1'b1, 1'b0, a);
    expect_at(e + 13, "F_accept", 3'b111, 3'b000, 3'b000, 3'b110, 1'b1, 1'b0);
    expect_at(e + 14, "F_load",   3'b111, 3'b000, 3'b000, 3'b110, 1'b1, 1'b1);
    expect_at(e + 15, "F_e15",    3'b111, 3'b100, 3'b100, 3'b110, 1'b0, 1'b0);
    expect_at(e + 18, "F_e18",    3'b111, 3'b110, 3'b010, 3'b110, 1'b0, 1'b0);

    // Out-of-range channel with sync still restarts the active channels
    wait_edge(e + 18);
    do_cfg(2'd3, 16'd0, 1'b0, 1'b1, a);
    l = a + 1;
    expect_at(l,     "G_load", 3'b111, 3'b000, 3'b000, 3'b110, 1'b1, 1'b1);
    expect_at(l + 3, "G_l3",   3'b111, 3'b100, 3'b100, 3'b110, 1'b0, 1'b0);
    expect_at(l + 6, "G_l6",   3'b111, 3'b110, 3'b010, 3'b110, 1'b0, 1'b0);
    wait_edge(l + 8);

    while (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: expectation due at edge %0d never checked (now %0d)",
               sb[0].nm, sb[0].cyc, ecount);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
